// File: rtl/pc_flow_controller.sv
`default_nettype none
// ============================================================================
// Module  : pc_flow_controller
// Purpose : Fetch-stage sequencer: next-PC selection, pipeline stall/flush/bubble
// Revision: 1.0
// ============================================================================
module pc_flow_controller #(
  parameter int                N_BITS     = 32,
  parameter logic [N_BITS-1:0] RESET_PC   = 32'h0040_0000,
  parameter logic [N_BITS-1:0] EXC_VECTOR = 32'h8000_0180,
  parameter int                TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] pc_value_i,
  input  logic              imem_ready_i,
  input  logic              load_use_hazard_i,
  input  logic              branch_taken_i,
  input  logic [N_BITS-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [N_BITS-1:0] jump_target_i,
  input  logic              halt_i,
  output logic [N_BITS-1:0] new_pc_o,
  output logic              pc_enable_o,
  output logic              if_id_enable_o,
  output logic              if_id_flush_o,
  output logic              id_ex_bubble_o,
  output logic              fault_o,
  output logic [15:0]       stall_cycles_o,
  output logic [1:0]        state_o
);

  localparam logic [1:0] ST_BOOT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;

  localparam logic [15:0] C_TIMEOUT   = 16'(TIMEOUT);
  localparam logic [15:0] C_STALL_MAX = 16'hFFFF;

  // The program counter itself owns RESET_PC; here it only needs to be word aligned.
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be in 2..65535");
  end

  logic [1:0]  state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        fault_q, fault_d;
  logic [15:0] stall_q, stall_d;

  logic              w_redirect;
  logic [N_BITS-1:0] w_redirect_pc;
  logic [15:0]       w_wait_inc;
  logic              w_timeout_hit;

  assign w_redirect    = jump_i | branch_taken_i;
  assign w_redirect_pc = jump_i ? jump_target_i : branch_target_i;
  assign w_wait_inc    = wait_cnt_q + 16'd1;
  // The RUN cycle that entered MEM_WAIT counts as not-ready cycle 1.
  assign w_timeout_hit = (w_wait_inc == C_TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      wait_cnt_q <= 16'd0;
      fault_q    <= 1'b0;
      stall_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    fault_d    = fault_q;
    stall_d    = stall_q;
    case (state_q)
      ST_BOOT: begin
        if (imem_ready_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        wait_cnt_d = 16'd0;
        if (halt_i) begin
          state_d = ST_HALTED;
        end else if (!w_redirect && !load_use_hazard_i && !imem_ready_i) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        wait_cnt_d = w_wait_inc;
        if (halt_i) begin
          state_d    = ST_HALTED;
          wait_cnt_d = 16'd0;
        end else if (w_redirect || imem_ready_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = 16'd0;
        end else if (w_timeout_hit) begin
          state_d    = ST_RUN;
          wait_cnt_d = 16'd0;
          fault_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
    if ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && !pc_enable_o
        && stall_q != C_STALL_MAX) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_comb begin
    new_pc_o       = pc_value_i + N_BITS'(4);
    pc_enable_o    = 1'b0;
    if_id_enable_o = 1'b0;
    if_id_flush_o  = 1'b1;
    id_ex_bubble_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt_i) begin
          if_id_flush_o = 1'b1;
        end else if (w_redirect) begin
          new_pc_o    = w_redirect_pc;
          pc_enable_o = 1'b1;
        end else if (load_use_hazard_i) begin
          if_id_flush_o  = 1'b0;
          id_ex_bubble_o = 1'b1;
        end else if (imem_ready_i) begin
          pc_enable_o    = 1'b1;
          if_id_enable_o = 1'b1;
          if_id_flush_o  = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        if (halt_i) begin
          if_id_flush_o = 1'b1;
        end else if (w_redirect) begin
          new_pc_o    = w_redirect_pc;
          pc_enable_o = 1'b1;
        end else if (imem_ready_i) begin
          pc_enable_o    = 1'b1;
          if_id_enable_o = 1'b1;
          if_id_flush_o  = 1'b0;
        end else if (w_timeout_hit) begin
          new_pc_o    = EXC_VECTOR;
          pc_enable_o = 1'b1;
        end
      end
      default: begin
        if_id_flush_o = 1'b1;
      end
    endcase
  end

  assign fault_o        = fault_q;
  assign stall_cycles_o = stall_q;
  assign state_o        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_flow_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_flow_controller
// Purpose : Directed-vector scoreboard bench for pc_flow_controller
// Revision: 1.0
// ============================================================================
module tb_pc_flow_controller;

  logic        clk;
  logic        reset;
  logic [31:0] pc_value_i;
  logic        imem_ready_i;
  logic        load_use_hazard_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        halt_i;
  logic [31:0] new_pc_o;
  logic        pc_enable_o;
  logic        if_id_enable_o;
  logic        if_id_flush_o;
  logic        id_ex_bubble_o;
  logic        fault_o;
  logic [15:0] stall_cycles_o;
  logic [1:0]  state_o;

  pc_flow_controller dut (
    .clk               (clk),
    .reset             (reset),
    .pc_value_i        (pc_value_i),
    .imem_ready_i      (imem_ready_i),
    .load_use_hazard_i (load_use_hazard_i),
    .branch_taken_i    (branch_taken_i),
    .branch_target_i   (branch_target_i),
    .jump_i            (jump_i),
    .jump_target_i     (jump_target_i),
    .halt_i            (halt_i),
    .new_pc_o          (new_pc_o),
    .pc_enable_o       (pc_enable_o),
    .if_id_enable_o    (if_id_enable_o),
    .if_id_flush_o     (if_id_flush_o),
    .id_ex_bubble_o    (id_ex_bubble_o),
    .fault_o           (fault_o),
    .stall_cycles_o    (stall_cycles_o),
    .state_o           (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] new_pc;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_care;
    logic        flush;
    logic        bubble;
    logic        fault;
    logic [15:0] stall;
    logic [1:0]  state;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Inputs change on the falling edge; outputs are sampled 2ns later, well before the rising edge.
  task automatic step(input string nm, input logic rst, input logic [31:0] pc,
                      input logic rdy, input logic lu, input logic br,
                      input logic [31:0] btgt, input logic jp, input logic [31:0] jtgt,
                      input logic hlt, input logic [31:0] e_pc, input logic e_pcen,
                      input logic e_ifid, input logic e_ifid_care, input logic e_flush,
                      input logic e_bub, input logic e_fault, input logic [15:0] e_stall,
                      input logic [1:0] e_state);
    exp_t e;
    @(negedge clk);
    reset             = rst;
    pc_value_i        = pc;
    imem_ready_i      = rdy;
    load_use_hazard_i = lu;
    branch_taken_i    = br;
    branch_target_i   = btgt;
    jump_i            = jp;
    jump_target_i     = jtgt;
    halt_i            = hlt;
    e.name = nm; e.new_pc = e_pc; e.pc_en = e_pcen; e.ifid_en = e_ifid;
    e.ifid_care = e_ifid_care; e.flush = e_flush; e.bubble = e_bub;
    e.fault = e_fault; e.stall = e_stall; e.state = e_state;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (new_pc_o !== e.new_pc || pc_enable_o !== e.pc_en ||
            (e.ifid_care && if_id_enable_o !== e.ifid_en) ||
            if_id_flush_o !== e.flush || id_ex_bubble_o !== e.bubble ||
            fault_o !== e.fault || stall_cycles_o !== e.stall || state_o !== e.state) begin
          failures++;
          $display("FAIL %s: got pc=%h en=%b ifid=%b fl=%b bub=%b flt=%b st=%0d state=%0d exp pc=%h en=%b ifid=%b fl=%b bub=%b flt=%b st=%0d state=%0d",
                   e.name, new_pc_o, pc_enable_o, if_id_enable_o, if_id_flush_o,
                   id_ex_bubble_o, fault_o, stall_cycles_o, state_o,
                   e.new_pc, e.pc_en, e.ifid_en, e.flush, e.bubble, e.fault,
                   e.stall, e.state);
        end
      end
    end
  end

  localparam logic [31:0] PC0 = 32'h0040_0000;
  localparam logic [31:0] PC1 = 32'h0040_0004;
  localparam logic [31:0] PC2 = 32'h0040_0008;
  localparam logic [31:0] PC3 = 32'h0040_000C;
  localparam logic [31:0] EXC = 32'h8000_0180;
  localparam logic [31:0] JT  = 32'h0040_0100;
  localparam logic [31:0] BT  = 32'h0040_0200;

  initial begin : stimulus
    int guard;
    reset = 1'b1; pc_value_i = PC0; imem_ready_i = 1'b0; load_use_hazard_i = 1'b0;
    branch_taken_i = 1'b0; branch_target_i = '0; jump_i = 1'b0; jump_target_i = '0;
    halt_i = 1'b0;
    repeat (2) @(posedge clk);

    //    name         rst pc   rdy lu br btgt jp jtgt hlt  e_pc e_en ifid care fl bub flt stall state
    step("reset",      1, PC0, 0, 0, 0, BT, 0, JT, 0,   PC1, 0, 0, 1, 1, 0, 0, 16'd0, 2'd0);
    for (int i = 0; i < 3; i++)
      step("boot_wait", 0, PC0, 0, 0, 0, BT, 0, JT, 0,  PC1, 0, 0, 1, 1, 0, 0, 16'd0, 2'd0);
    step("boot_ready", 0, PC0, 1, 0, 0, BT, 0, JT, 0,   PC1, 0, 0, 1, 1, 0, 0, 16'd0, 2'd0);
    step("seq",        0, PC0, 1, 0, 0, BT, 0, JT, 0,   PC1, 1, 1, 1, 0, 0, 0, 16'd0, 2'd1);
    step("jump_br",    0, PC1, 0, 0, 1, BT, 1, JT, 0,   JT,  1, 0, 0, 1, 0, 0, 16'd0, 2'd1);
    step("branch",     0, JT,  1, 0, 1, BT, 0, JT, 0,   BT,  1, 0, 0, 1, 0, 0, 16'd0, 2'd1);
    step("load_use",   0, BT,  1, 1, 0, BT, 0, JT, 0,   BT + 32'd4, 0, 0, 1, 0, 1, 0, 16'd0, 2'd1);
    step("after_lu",   0, PC0, 1, 0, 0, BT, 0, JT, 0,   PC1, 1, 1, 1, 0, 0, 0, 16'd1, 2'd1);
    step("wrap",       0, 32'hFFFF_FFFC, 1, 0, 0, BT, 0, JT, 0, 32'h0, 1, 1, 1, 0, 0, 0, 16'd1, 2'd1);

    // Ready comes back on the 15th not-ready cycle: no fault.
    step("nr_enter",   0, PC2, 0, 0, 0, BT, 0, JT, 0,   PC3, 0, 0, 1, 1, 0, 0, 16'd1, 2'd1);
    for (int k = 2; k <= 14; k++)
      step("nr_wait",  0, PC2, 0, 0, 0, BT, 0, JT, 0,   PC3, 0, 0, 1, 1, 0, 0, 16'(k), 2'd2);
    step("nr_ready15", 0, PC2, 1, 0, 0, BT, 0, JT, 0,   PC3, 1, 1, 1, 0, 0, 0, 16'd15, 2'd2);
    step("nr_run",     0, PC3, 1, 0, 0, BT, 0, JT, 0,   PC3 + 32'd4, 1, 1, 1, 0, 0, 0, 16'd15, 2'd1);

    // Ready held low: exception redirect on the 16th cycle.
    step("to_enter",   0, PC2, 0, 0, 0, BT, 0, JT, 0,   PC3, 0, 0, 1, 1, 0, 0, 16'd15, 2'd1);
    for (int k = 2; k <= 15; k++)
      step("to_wait",  0, PC2, 0, 0, 0, BT, 0, JT, 0,   PC3, 0, 0, 1, 1, 0, 0, 16'(k + 14), 2'd2);
    step("to_fire16",  0, PC2, 0, 0, 0, BT, 0, JT, 0,   EXC, 1, 0, 0, 1, 0, 0, 16'd30, 2'd2);
    step("to_sticky",  0, EXC, 1, 0, 0, BT, 0, JT, 0,   EXC + 32'd4, 1, 1, 1, 0, 0, 1, 16'd30, 2'd1);

    // Halt while waiting on memory.
    step("h_enter",    0, PC0, 0, 0, 0, BT, 0, JT, 0,   PC1, 0, 0, 1, 1, 0, 1, 16'd30, 2'd1);
    step("h_mw_halt",  0, PC0, 0, 0, 0, BT, 0, JT, 1,   PC1, 0, 0, 1, 1, 0, 1, 16'd31, 2'd2);
    step("halted",     0, PC0, 1, 0, 0, BT, 0, JT, 0,   PC1, 0, 0, 1, 1, 0, 1, 16'd32, 2'd3);
    step("halted_jmp", 0, PC0, 1, 0, 1, BT, 1, JT, 0,   PC1, 0, 0, 1, 1, 0, 1, 16'd32, 2'd3);
    step("reset_mid",  1, PC0, 1, 0, 0, BT, 0, JT, 0,   PC1, 0, 0, 1, 1, 0, 0, 16'd0, 2'd0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
